// File: rtl/mmio_spi_slave_if.sv
// Core data-bus port of the MMIO SPI slave: store strobe, word address, store data, load data.
interface mmio_spi_slave_if;
  logic        MemWrite;
  logic [12:0] DataAdr;
  logic [15:0] WriteData;
  logic [15:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/mmio_spi_slave.sv
// Memory-mapped SPI slave (mode 0, MSB first, 16-bit words) with TX/RX FIFOs between
// the core bus and the oversampled SPI link.
module mmio_spi_slave #(
  parameter logic [12:0] BASE_ADR = 13'h1F00,
  parameter int unsigned DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  mmio_spi_slave_if.slave bus,
  input  logic            spi_sclk,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            irq
);
  localparam int unsigned WW = 16;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

  state_t        state;
  logic [2:0]    sclk_s, cs_s;
  logic [1:0]    mosi_s;
  logic [WW-1:0] tx_sh, rx_sh, rx_word;
  logic [3:0]    bit_cnt;
  logic [WW-1:0] tx_mem [DEPTH];
  logic [WW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [CW-1:0] tx_cnt, rx_cnt, rx_cnt_nxt;
  logic          tx_unf, rx_ovf, tx_ovf;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, busy;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic sel_tx, sel_rx, sel_st;
  logic tx_push, tx_pop, rx_push, rx_pop, word_done, unf_set;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign busy      = ~cs_s[1];

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign sel_tx = bus.MemWrite & (bus.DataAdr == BASE_ADR);
  assign sel_rx = bus.MemWrite & (bus.DataAdr == BASE_ADR + 13'd1);
  assign sel_st = bus.MemWrite & (bus.DataAdr == BASE_ADR + 13'd2);

  // A cs_n rise aborts whatever the link side would have done this cycle.
  assign word_done = (state == SHIFT) & sclk_rise & (bit_cnt == 4'd15) & ~cs_rise;
  assign tx_pop    = (state == LOAD) & ~tx_empty & ~cs_rise;
  assign unf_set   = (state == LOAD) & tx_empty & ~cs_rise;
  assign tx_push   = sel_tx & (~tx_full | tx_pop);
  assign rx_pop    = sel_rx & ~rx_empty;
  assign rx_push   = word_done & (~rx_full | rx_pop);
  assign rx_word   = {rx_sh[WW-2:0], mosi_s[1]};

  assign rx_cnt_nxt = rx_cnt + CW'(rx_push) - CW'(rx_pop);
  assign spi_miso   = busy & tx_sh[WW-1];

  // Two-stage synchronizers plus one history stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk};
      cs_s   <= {cs_s[1:0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.WriteData;
    if (rx_push) rx_mem[rx_wr] <= rx_word;
  end

  // FIFO pointers, occupancy, sticky flags and irq; a flag being set wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      rx_rd  <= '0;
      rx_wr  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      tx_unf <= 1'b0;
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_cnt <= rx_cnt_nxt;
      tx_unf <= unf_set | (tx_unf & ~(sel_st & bus.WriteData[4]));
      rx_ovf <= (word_done & ~rx_push) | (rx_ovf & ~(sel_st & bus.WriteData[5]));
      tx_ovf <= (sel_tx & ~tx_push) | (tx_ovf & ~(sel_st & bus.WriteData[7]));
      irq    <= (rx_cnt_nxt != '0);
    end
  end

  // Link FSM; bit_cnt stays 0 until the first rise so the loaded MSB survives the first fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else if (cs_rise) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state <= LOAD;
        LOAD: begin
          tx_sh   <= tx_empty ? '0 : tx_mem[tx_rd];
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_sh   <= rx_word;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state <= LOAD;
          end else if (sclk_fall && bit_cnt != 4'd0) begin
            tx_sh <= tx_sh << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.DataAdr == BASE_ADR + 13'd1) begin
      bus.ReadData = rx_empty ? '0 : rx_mem[rx_rd];
    end else if (bus.DataAdr == BASE_ADR + 13'd2) begin
      bus.ReadData = {8'h00, tx_ovf, busy, rx_ovf, tx_unf, rx_full, rx_empty, tx_empty, tx_full};
    end
  end
endmodule

// File: tb/tb_mmio_spi_slave.sv
// Bench for mmio_spi_slave: register-map vector table, directed link sequences and
// randomized traffic checked against a queue-based model of the peripheral.
module tb_mmio_spi_slave;
  localparam int          DEPTH = 4;
  localparam logic [12:0] A_TX  = 13'h1F00;
  localparam logic [12:0] A_RX  = 13'h1F01;
  localparam logic [12:0] A_ST  = 13'h1F02;
  localparam int          HALF  = 50;

  logic clk, reset, spi_sclk, spi_cs_n, spi_mosi, spi_miso, irq;
  mmio_spi_slave_if bus ();

  mmio_spi_slave #(.BASE_ADR(A_TX), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, irq_lat;
  logic [15:0] mosi_buf [4];
  logic [15:0] miso_buf [4];
  logic [15:0] rd;

  logic [15:0] m_tx [$];
  logic [15:0] m_rx [$];
  logic m_unf, m_rovf, m_tovf;

  typedef struct {
    logic        wr;
    logic [12:0] adr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs [24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] m_status();
    return {8'h00, m_tovf, 1'b0, m_rovf, m_unf, m_rx.size() == DEPTH,
            m_rx.size() == 0, m_tx.size() == 0, m_tx.size() == DEPTH};
  endfunction

  function automatic logic [15:0] m_tx_pop();
    if (m_tx.size() == 0) begin
      m_unf = 1'b1;
      return 16'h0000;
    end
    return m_tx.pop_front();
  endfunction

  task automatic m_reset();
    m_tx.delete();
    m_rx.delete();
    m_unf = 0; m_rovf = 0; m_tovf = 0;
  endtask

  task automatic bus_wr(input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.MemWrite = 1'b1; bus.DataAdr = a; bus.WriteData = d;
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [12:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.DataAdr = a;
    #1 d = bus.ReadData;
  endtask

  task automatic cpu_wr(input logic [12:0] a, input logic [15:0] d);
    bus_wr(a, d);
    if (a == A_TX) begin
      if (m_tx.size() < DEPTH) m_tx.push_back(d);
      else m_tovf = 1'b1;
    end else if (a == A_RX) begin
      if (m_rx.size() > 0) void'(m_rx.pop_front());
    end else if (a == A_ST) begin
      if (d[4]) m_unf = 1'b0;
      if (d[5]) m_rovf = 1'b0;
      if (d[7]) m_tovf = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [15:0] v;
    bus_rd(A_ST, v);
    check({tag, " status"}, v, m_status());
    bus_rd(A_RX, v);
    check({tag, " rxdata"}, v, (m_rx.size() != 0) ? m_rx[0] : 16'h0000);
    check({tag, " irq"}, 16'(irq), 16'(m_rx.size() != 0));
  endtask

  // One cs_n-framed burst; a frame ending on a full word lets the slave re-enter LOAD
  // (one more TX pop) before cs_n rises.
  task automatic spi_xfer(input int nwords, input int last_bits);
    logic [15:0] exp_w;
    irq_lat = -1;
    @(negedge clk);
    spi_cs_n = 1'b0;
    #(2*HALF);
    for (int w = 0; w < nwords; w++) begin
      int nb;
      nb = (w == nwords - 1) ? last_bits : 16;
      exp_w = m_tx_pop();
      miso_buf[w] = '0;
      for (int b = 0; b < nb; b++) begin
        spi_mosi = mosi_buf[w][15-b];
        #HALF;
        miso_buf[w][15-b] = spi_miso;
        spi_sclk = 1'b1;
        if (w == nwords - 1 && b == 15) begin
          for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (irq && irq_lat < 0) irq_lat = c;
          end
        end else begin
          #HALF;
        end
        spi_sclk = 1'b0;
      end
      if (nb == 16) begin
        check($sformatf("miso word %0d", w), miso_buf[w], exp_w);
        if (m_rx.size() < DEPTH) m_rx.push_back(mosi_buf[w]);
        else m_rovf = 1'b1;
      end
    end
    if (last_bits == 16) void'(m_tx_pop());
    #HALF;
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    m_reset();
    #33 reset = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    bus_rd(A_ST, rd);
    check("reset status", rd, 16'h0006);
    check("reset irq", 16'(irq), 16'h0000);
    check("reset miso", 16'(spi_miso), 16'h0000);

    // register map table
    vecs[0]  = '{1'b0, A_ST, 16'h0006};
    vecs[1]  = '{1'b1, A_TX, 16'hA5C3};
    vecs[2]  = '{1'b0, A_ST, 16'h0004};
    vecs[3]  = '{1'b0, A_RX, 16'h0000};
    vecs[4]  = '{1'b0, A_TX, 16'h0000};
    vecs[5]  = '{1'b0, 13'h1EFF, 16'h0000};
    vecs[6]  = '{1'b0, 13'h1F03, 16'h0000};
    vecs[7]  = '{1'b1, A_TX, 16'h0001};
    vecs[8]  = '{1'b1, A_TX, 16'h0002};
    vecs[9]  = '{1'b1, A_TX, 16'h0003};
    vecs[10] = '{1'b0, A_ST, 16'h0005};
    vecs[11] = '{1'b1, A_TX, 16'h0004};
    vecs[12] = '{1'b0, A_ST, 16'h0085};
    vecs[13] = '{1'b1, A_RX, 16'h1234};
    vecs[14] = '{1'b0, A_ST, 16'h0085};
    vecs[15] = '{1'b1, A_ST, 16'h0070};
    vecs[16] = '{1'b0, A_ST, 16'h0085};
    vecs[17] = '{1'b1, A_ST, 16'hFF7F};
    vecs[18] = '{1'b0, A_ST, 16'h0085};
    vecs[19] = '{1'b1, A_ST, 16'h0080};
    vecs[20] = '{1'b0, A_ST, 16'h0005};
    vecs[21] = '{1'b1, 13'h1F03, 16'hFFFF};
    vecs[22] = '{1'b0, A_ST, 16'h0005};
    vecs[23] = '{1'b0, A_RX, 16'h0000};
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].adr, vecs[i].data);
      else begin
        bus_rd(vecs[i].adr, rd);
        check($sformatf("vec %0d adr %h", i, vecs[i].adr), rd, vecs[i].data);
      end
    end

    @(negedge clk) reset = 1'b0;
    m_reset();
    #20 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_state("after table");

    // single word exchange with irq latency
    cpu_wr(A_TX, 16'hA5C3);
    mosi_buf[0] = 16'h1234;
    spi_xfer(1, 16);
    check("t2 miso", miso_buf[0], 16'hA5C3);
    check("t2 irq latency ok", 16'(irq_lat >= 1 && irq_lat <= 4), 16'h0001);
    bus_rd(A_RX, rd);
    check("t2 rxdata", rd, 16'h1234);
    bus_rd(A_ST, rd);
    check("t2 txempty", 16'(rd[1]), 16'h0001);
    check_state("t2");
    cpu_wr(A_RX, 16'h0);

    // underflow frame and sticky clear
    mosi_buf[0] = 16'h5A5A;
    spi_xfer(1, 16);
    check("t3 miso", miso_buf[0], 16'h0000);
    bus_rd(A_ST, rd);
    check("t3 txunf", 16'(rd[4]), 16'h0001);
    cpu_wr(A_ST, 16'h0010);
    bus_rd(A_ST, rd);
    check("t3 txunf cleared", 16'(rd[4]), 16'h0000);
    cpu_wr(A_RX, 16'h0);
    check_state("t3");

    // TX overflow and back-to-back words
    for (int i = 1; i <= 5; i++) cpu_wr(A_TX, 16'(i));
    bus_rd(A_ST, rd);
    check("t4 txfull", 16'(rd[0]), 16'h0001);
    check("t4 txovf", 16'(rd[7]), 16'h0001);
    mosi_buf[0] = 16'hBEEF; mosi_buf[1] = 16'hCAFE;
    spi_xfer(2, 16);
    check("t4 miso0", miso_buf[0], 16'h0001);
    check("t4 miso1", miso_buf[1], 16'h0002);
    check_state("t4");
    cpu_wr(A_RX, 16'h0); cpu_wr(A_RX, 16'h0);
    cpu_wr(A_ST, 16'h00B0);

    // RX overflow
    for (int i = 0; i < 5; i++) begin
      mosi_buf[0] = 16'h1000 + 16'(i);
      spi_xfer(1, 16);
    end
    bus_rd(A_ST, rd);
    check("t5 rxovf", 16'(rd[5]), 16'h0001);
    check_state("t5");
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_RX, rd);
      check($sformatf("t5 rx pop %0d", i), rd, 16'h1000 + 16'(i));
      cpu_wr(A_RX, 16'h0);
    end
    cpu_wr(A_ST, 16'h00B0);
    check_state("t5 drained");

    // aborted frame then mid-frame reset
    cpu_wr(A_TX, 16'h7777); cpu_wr(A_TX, 16'h8888);
    mosi_buf[0] = 16'hF0F0;
    spi_xfer(1, 7);
    check_state("t6 abort");
    mosi_buf[0] = 16'h0F0F;
    spi_xfer(1, 16);
    check("t6 next miso", miso_buf[0], 16'h8888);
    cpu_wr(A_TX, 16'h9999);
    @(negedge clk) spi_cs_n = 1'b0;
    #(2*HALF);
    repeat (3) begin
      spi_mosi = 1'b1; #HALF; spi_sclk = 1'b1; #HALF; spi_sclk = 1'b0;
    end
    reset = 1'b0; spi_cs_n = 1'b1;
    m_reset();
    #30 reset = 1'b1;
    repeat (5) @(negedge clk);
    bus_rd(A_ST, rd);
    check("t6 reset status", rd, 16'h0006);
    check("t6 reset irq", 16'(irq), 16'h0000);
    check("t6 reset miso", 16'(spi_miso), 16'h0000);
    check_state("t6 reset");

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: cpu_wr(A_TX, 16'($urandom));
        1: cpu_wr(A_RX, 16'($urandom));
        2: begin
          int nw, lb;
          nw = $urandom_range(1, 2);
          lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
          for (int w = 0; w < 4; w++) mosi_buf[w] = 16'($urandom);
          spi_xfer(nw, lb);
        end
        3: cpu_wr(A_ST, 16'($urandom));
        default: ;
      endcase
      check_state($sformatf("rand %0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
